// File: rtl/axi_dw_downsize_w_seq.sv
// axi_dw_downsize_w_seq: write-data sequencer for an AXI data-width downsizer.
// Queues accepted AW commands and, for each wide W beat, issues the narrow
// beats that cover the active bytes. It drives the narrow lane select, and it
// consumes the wide beat on the last narrow handshake of that beat.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  AW command handshake (addr, len, size, burst)
//   slv_w_valid_i/_last_i      wide W beat present and its last flag
//   slv_w_ready_o              wide beat consumed
//   mst_w_valid_o/_ready_i     narrow beat handshake
//   mst_w_last_o               final narrow beat of the burst
//   lane_sel_o                 narrow lane currently driven
//   busy_o                     burst in progress
//   last_err_o                 one-cycle pulse on a W-last mismatch
//   mst_beat_cnt_o             narrow handshake counter
//
// Optional feature: define AXI_DW_DOWNSIZE_W_SEQ_PERF_EN to build the narrow
// beat counter. Without it, mst_beat_cnt_o is tied to zero.
module axi_dw_downsize_w_seq #(
   parameter int unsigned AxiAddrWidth    = 64,
   parameter int unsigned AxiSlvDataWidth = 64,
   parameter int unsigned AxiMstDataWidth = 32,
   parameter int unsigned AxiMaxTrans     = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [AxiAddrWidth-1:0] cmd_addr_i,
   input  logic [7:0]              cmd_len_i,
   input  logic [2:0]              cmd_size_i,
   input  logic [1:0]              cmd_burst_i,
   input  logic                    slv_w_valid_i,
   input  logic                    slv_w_last_i,
   output logic                    slv_w_ready_o,
   output logic                    mst_w_valid_o,
   input  logic                    mst_w_ready_i,
   output logic                    mst_w_last_o,
   output logic [$clog2(AxiSlvDataWidth/AxiMstDataWidth)-1:0] lane_sel_o,
   output logic                    busy_o,
   output logic                    last_err_o,
   output logic [31:0]             mst_beat_cnt_o
);

   localparam int unsigned mst_off = $clog2(AxiMstDataWidth / 8);
   localparam int unsigned slv_off = $clog2(AxiSlvDataWidth / 8);
   localparam int unsigned lane_w  = slv_off - mst_off;
   localparam int unsigned nb_w    = lane_w + 1;
   localparam int unsigned ptr_w   = (AxiMaxTrans > 1) ? $clog2(AxiMaxTrans) : 1;
   localparam int unsigned cnt_w   = $clog2(AxiMaxTrans + 1);

   localparam logic [1:0] burst_fixed = 2'b00;

   typedef struct packed {
      logic [AxiAddrWidth-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
   } cmd_t;

   typedef enum logic {IDLE, SEND} state_t;

   // Sizes wider than the slave bus are treated as full-width beats.
   function automatic logic [2:0] eff_size(input logic [2:0] sz);
      if (32'(sz) > slv_off) return 3'(slv_off);
      return sz;
   endfunction

   // Narrow beats needed for one wide beat starting at lane ln.
   function automatic logic [nb_w-1:0] beats_of(input logic [lane_w-1:0] ln,
                                                 input logic [2:0]        sz);
      logic [2:0]      k;
      logic [nb_w-1:0] span;
      logic [nb_w-1:0] mask;
      if (32'(sz) <= mst_off) return nb_w'(1);
      k    = sz - 3'(mst_off);
      span = nb_w'(1) << k;
      mask = span - nb_w'(1);
      return span - ({1'b0, ln} & mask);
   endfunction

   // Next size-aligned address for INCR/WRAP (wrap boundary not applied).
   function automatic logic [AxiAddrWidth-1:0] next_addr(input logic [AxiAddrWidth-1:0] a,
                                                         input logic [2:0]              sz);
      logic [AxiAddrWidth-1:0] step;
      step = AxiAddrWidth'(1) << sz;
      return (a & ~(step - AxiAddrWidth'(1))) + step;
   endfunction

   function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
      if (p == ptr_w'(AxiMaxTrans - 1)) return '0;
      return p + ptr_w'(1);
   endfunction

   // Command FIFO
   cmd_t             mem [AxiMaxTrans];
   logic [ptr_w-1:0] wr_q;
   logic [ptr_w-1:0] rd_q;
   logic [cnt_w-1:0] cnt_q;
   cmd_t             cmd_in;
   cmd_t             head;
   logic             push;
   logic             pop;

   // Burst state
   state_t                  state_q;
   logic [AxiAddrWidth-1:0] addr_q;
   logic [7:0]              len_q;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic [7:0]              beat_q;
   logic [lane_w-1:0]       lane_q;
   logic [nb_w-1:0]         nb_q;
   logic                    err_q;

   logic                    hs;
   logic                    wide_last;
   logic                    burst_last;
   logic [AxiAddrWidth-1:0] nxt_addr;
   logic [lane_w-1:0]       nxt_lane;
   logic [2:0]              head_size;
   logic [lane_w-1:0]       head_lane;

   assign cmd_in = '{addr: cmd_addr_i, len: cmd_len_i, size: cmd_size_i, burst: cmd_burst_i};
   assign head   = mem[rd_q];

   // Pop only depends on registered state, so a full FIFO can accept in the pop cycle.
   assign pop         = (state_q == IDLE) && (cnt_q != '0);
   assign cmd_ready_o = (cnt_q != cnt_w'(AxiMaxTrans)) || pop;
   assign push        = cmd_valid_i && cmd_ready_o;

   assign mst_w_valid_o = (state_q == SEND) && slv_w_valid_i;
   assign hs            = mst_w_valid_o && mst_w_ready_i;
   assign wide_last     = (nb_q == nb_w'(1));
   assign burst_last    = (beat_q == len_q);
   assign slv_w_ready_o = hs && wide_last;
   assign mst_w_last_o  = (state_q == SEND) && wide_last && burst_last;
   assign busy_o        = (state_q == SEND);
   assign lane_sel_o    = lane_q;
   assign last_err_o    = err_q;

   // FIXED bursts keep the original address, hence the original lane.
   assign nxt_addr  = next_addr(addr_q, size_q);
   assign nxt_lane  = (burst_q == burst_fixed) ? addr_q[slv_off-1:mst_off]
                                               : nxt_addr[slv_off-1:mst_off];
   assign head_size = eff_size(head.size);
   assign head_lane = head.addr[slv_off-1:mst_off];

   // FIFO storage, no reset needed: occupancy is tracked by cnt_q.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_q] <= cmd_in;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= ptr_inc(wr_q);
         if (pop)  rd_q <= ptr_inc(rd_q);
         if (push && !pop)      cnt_q <= cnt_q + cnt_w'(1);
         else if (pop && !push) cnt_q <= cnt_q - cnt_w'(1);
      end
   end

   // Burst sequencer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         beat_q  <= '0;
         lane_q  <= '0;
         nb_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= slv_w_ready_o && (slv_w_last_i != burst_last);
         if (state_q == IDLE) begin
            if (pop) begin
               state_q <= SEND;
               addr_q  <= head.addr;
               len_q   <= head.len;
               size_q  <= head_size;
               burst_q <= head.burst;
               beat_q  <= '0;
               lane_q  <= head_lane;
               nb_q    <= beats_of(head_lane, head_size);
            end
         end else if (hs) begin
            if (wide_last) begin
               if (burst_last) begin
                  state_q <= IDLE;
               end else begin
                  beat_q <= beat_q + 8'd1;
                  if (burst_q != burst_fixed) addr_q <= nxt_addr;
                  lane_q <= nxt_lane;
                  nb_q   <= beats_of(nxt_lane, size_q);
               end
            end else begin
               lane_q <= lane_q + lane_w'(1);
               nb_q   <= nb_q - nb_w'(1);
            end
         end
      end
   end

`ifdef AXI_DW_DOWNSIZE_W_SEQ_PERF_EN
   logic [31:0] perf_q;

   // Narrow handshake counter, wraps naturally at 2^32.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)  perf_q <= '0;
      else if (hs)  perf_q <= perf_q + 32'd1;
   end

   assign mst_beat_cnt_o = perf_q;
`else
   assign mst_beat_cnt_o = '0;
`endif

endmodule
